mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / load-store) arbiter in front
// of a single-port synchronous memory. Grants are combinational, and at most
// one requester is granted per cycle. A registered owner tag steers the read
// response, which arrives one cycle later, to the requester that issued it.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard. When the macro is undefined, data requests always have
// priority and starve_cnt is tied to 0.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        starve_cnt
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  owner_e     owner_q, owner_d;
  logic       starve_force;
  logic [2:0] starve_q;

  // Arbitration. Data normally wins. A saturated starve count hands the slot
  // to fetch. Both grants are held low while reset is asserted.
  always_comb begin
    d_gnt  = rst_n & d_req & ~(starve_force & if_req);
    if_gnt = rst_n & if_req & ~d_gnt;
  end

  // Memory port: the address follows the winner. Fetch address is the idle default.
  always_comb begin
    mem_addr  = d_gnt ? d_addr : if_addr;
    mem_we    = d_gnt & d_we;
    mem_wdata = d_wdata;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  assign starve_force = (starve_q == LIMIT);

  // Count consecutive denied fetch cycles, saturating at the limit. The count
  // clears on a fetch grant or when fetch stops requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                starve_q <= '0;
    else if (if_req && !if_gnt) starve_q <= (starve_q == LIMIT) ? LIMIT : starve_q + 3'd1;
    else                       starve_q <= '0;
  end
`else
  assign starve_force = 1'b0;
  assign starve_q     = '0;
`endif

  assign starve_cnt = starve_q;

  // Owner tag register. Reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  // Next owner: only reads produce a response. Stores and idle cycles produce none.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)              owner_d = OWN_IF;
    else if (d_gnt && !d_we) owner_d = OWN_D;
  end

  // Response steering. The read data bus is shared, and rvalid qualifies it.
  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    d_rvalid  = (owner_q == OWN_D);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, scoreboarded bench for mem_arbiter. Every read
// grant pushes the expected owner and data into a queue. The entry is popped
// and compared one cycle later, when the response is due. Expectations for
// the starvation guard follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [2:0]    starve_cnt;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int idx);
    return 32'hA5A5_0000 | 32'(idx);
  endfunction

  // Synchronous memory: read data appears one cycle after the address.
  logic [31:0] mem [256];
  logic        wr  [256];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr[mem_addr[9:2]]  <= 1'b1;
    end
    mem_rdata <= wr[mem_addr[9:2]] ? mem[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
  end

  typedef struct { bit is_d; logic [31:0] data; } rsp_t;
  rsp_t        q[$];
  logic [31:0] sh [256];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle. Inputs are already driven at the negedge. The task checks the
  // combinational outputs, then checks the response after the posedge.
  task automatic cyc(input logic eig, input logic edg, input logic [31:0] eaddr,
                     input logic ewe, input logic [2:0] est);
    rsp_t r;
    #1;
    chk("if_gnt", 64'(if_gnt), 64'(eig));
    chk("d_gnt", 64'(d_gnt), 64'(edg));
    chk("mem_addr", 64'(mem_addr), 64'(eaddr));
    chk("mem_we", 64'(mem_we), 64'(ewe));
    chk("starve_cnt", 64'(starve_cnt), 64'(est));
    if (ewe) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
    if (eig)              q.push_back('{1'b0, sh[if_addr[9:2]]});
    else if (edg && !d_we) q.push_back('{1'b1, sh[d_addr[9:2]]});
    if (edg && d_we) sh[d_addr[9:2]] = d_wdata;
    @(posedge clk); #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("if_rvalid", 64'(if_rvalid), 64'(!r.is_d));
      chk("d_rvalid", 64'(d_rvalid), 64'(r.is_d));
      chk("rdata", 64'(r.is_d ? d_rdata : if_rdata), 64'(r.data));
    end else begin
      chk("if_rvalid_idle", 64'(if_rvalid), 64'd0);
      chk("d_rvalid_idle", 64'(d_rvalid), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sh[i] = init_word(i);
      wr[i] = 1'b0;
    end
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h100; d_addr = 32'h200; d_wdata = '0;

    // Reset: requests present, but nothing may be granted.
    @(negedge clk); #1;
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("rst_starve", 64'(starve_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Lone fetch. This is also the first grant after reset release.
    if_req = 1'b1; if_addr = 32'h100;
    cyc(1, 0, 32'h100, 0, 0);
    if_req = 1'b0;
    cyc(0, 0, 32'h100, 0, 0);

    // Store to 0x40: one cycle of mem_we and no response. Then read it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    cyc(0, 1, 32'h40, 1, 0);
    d_req = 1'b0; d_we = 1'b0;
    cyc(0, 0, 32'h100, 0, 0);
    d_req = 1'b1; d_addr = 32'h40;
    cyc(0, 1, 32'h40, 0, 0);
    d_req = 1'b0;

    // Contention: the load wins. Hold both requests to exercise the guard.
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) cyc(0, 1, 32'h200, 0, 3'(k));
    cyc(1, 0, 32'h100, 0, 4);
    if_req = 1'b0;
    cyc(0, 1, 32'h200, 0, 0);
`else
    for (int k = 0; k < 6; k++) cyc(0, 1, 32'h200, 0, 0);
    d_req = 1'b0;
    cyc(1, 0, 32'h100, 0, 0);
    if_req = 1'b0;
`endif
    d_req = 1'b0;
    cyc(0, 0, 32'h100, 0, 0);

    // Alternate fetch and load grants back to back.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        if_req = 1'b1; if_addr = 32'h10 + 32'(8 * k); d_req = 1'b0;
        cyc(1, 0, if_addr, 0, 0);
      end else begin
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300 + 32'(4 * k);
        cyc(0, 1, d_addr, 0, 0);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc(0, 0, if_addr, 0, 0);

    // Reset during a granted fetch: the pending response is discarded.
    if_req = 1'b1; if_addr = 32'h80;
    #1;
    chk("pre_rst_if_gnt", 64'(if_gnt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("in_rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("in_rst_mem_we", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    chk("in_rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("in_rst_starve", 64'(starve_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; if_req = 1'b0;
    cyc(0, 0, 32'h80, 0, 0);
    cyc(0, 0, 32'h80, 0, 0);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
